// File: rtl/reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// reg_access_arbiter
//
// Purpose:
//   Shares the single register_map access port between two requesters:
//   requester 0 is the SPI-side master (already in the clk_i domain) and
//   requester 1 is the on-chip sequencer. Accesses are serialised through an
//   IDLE -> ISSUE -> ACK state machine. Addresses are range-checked against
//   NUM_REG, and the read data and completion pulse are returned to whichever
//   requester won arbitration.
//
// Configuration macro:
//   REG_ARB_ROUND_ROBIN_EN
//     defined     : on contention, the requester that was not granted last
//                   wins. No requester waits more than one other access.
//     not defined : fixed priority, requester 0 always wins contention.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active-high
//   req_i[1:0]   per-requester access request (level, held until ack)
//   we_i[1:0]    per-requester 1 = write, 0 = read
//   addr_i       packed per-requester addresses, requester n at [n*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata_i      packed per-requester write data, same packing
//   ack_o[1:0]   one-cycle completion pulse to the granted requester
//   err_o        valid with ack_o, 1 = address out of range, no access made
//   rdata_o      read data, valid with ack_o (0 for writes and errors)
//   busy_o       state machine not in IDLE
//   mem_addr_o   register_map address
//   mem_wdata_o  register_map write data
//   mem_we_o     register_map write strobe (one-cycle pulse)
//   mem_re_o     register_map read strobe (one-cycle pulse)
//   mem_rdata_i  register_map read data (combinational, same cycle as mem_re_o)
// ---------------------------------------------------------------------------
module reg_access_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REG    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              req_i,
  input  logic [1:0]              we_i,
  input  logic [2*ADDR_WIDTH-1:0] addr_i,
  input  logic [2*DATA_WIDTH-1:0] wdata_i,
  output logic [1:0]              ack_o,
  output logic                    err_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    busy_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic                    mem_we_o,
  output logic                    mem_re_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam logic [ADDR_WIDTH-1:0] NUM_REG_L = ADDR_WIDTH'(NUM_REG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic                    winner, winner_next;
  logic                    err_lat, err_lat_next;
  logic                    grant_sel;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    in_range;
  logic [1:0]              ack_next;
  logic                    err_next;
  logic [DATA_WIDTH-1:0]   rdata_next;
  logic                    busy_next;
  logic [ADDR_WIDTH-1:0]   mem_addr_next;
  logic [DATA_WIDTH-1:0]   mem_wdata_next;
  logic                    mem_we_next;
  logic                    mem_re_next;
`ifdef REG_ARB_ROUND_ROBIN_EN
  logic                    last_grant, last_grant_next;
`endif

  // Arbitration: decide which requester would be granted if the machine
  // were idle right now, and pick out that requester's request fields.
  // With round robin, a lone requester always wins and on contention the
  // one that was not granted last time takes its turn. Without it,
  // requester 1 only wins when requester 0 is not asking.
  always_comb begin
`ifdef REG_ARB_ROUND_ROBIN_EN
    grant_sel = req_i[1] & (~req_i[0] | ~last_grant);
`else
    grant_sel = ~req_i[0];
`endif
    sel_we    = grant_sel ? we_i[1] : we_i[0];
    sel_addr  = grant_sel ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0];
    sel_wdata = grant_sel ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];
    in_range  = (sel_addr < NUM_REG_L);
  end

  // Next-state and next-output logic. Every output is registered, so this
  // block computes what the outputs should show in the coming cycle. The
  // request fields are captured only in IDLE. The memory address and data
  // registers therefore act as the latch for the access and keep their value
  // while idle. An out-of-range access leaves them untouched and only records
  // the error flag. Read data is taken from the register map during the
  // ISSUE cycle, while the read strobe is high.
  always_comb begin
    state_next     = state;
    winner_next    = winner;
    err_lat_next   = err_lat;
    ack_next       = 2'b00;
    err_next       = 1'b0;
    rdata_next     = '0;
    mem_addr_next  = mem_addr_o;
    mem_wdata_next = mem_wdata_o;
    mem_we_next    = 1'b0;
    mem_re_next    = 1'b0;
`ifdef REG_ARB_ROUND_ROBIN_EN
    last_grant_next = last_grant;
`endif
    case (state)
      IDLE: begin
        if (|req_i) begin
          state_next   = ISSUE;
          winner_next  = grant_sel;
          err_lat_next = ~in_range;
`ifdef REG_ARB_ROUND_ROBIN_EN
          last_grant_next = grant_sel;
`endif
          if (in_range) begin
            mem_addr_next  = sel_addr;
            mem_wdata_next = sel_wdata;
            mem_we_next    = sel_we;
            mem_re_next    = ~sel_we;
          end
        end
      end
      ISSUE: begin
        state_next = ACK;
        ack_next   = winner ? 2'b10 : 2'b01;
        err_next   = err_lat;
        rdata_next = mem_re_o ? mem_rdata_i : '0;
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // State and output registers. A reset aborts any access in flight, so
  // its strobe or acknowledge never appears. After reset the round-robin
  // pointer marks requester 1 as the last one granted, so requester 0 wins
  // the first contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      winner      <= 1'b0;
      err_lat     <= 1'b0;
      ack_o       <= 2'b00;
      err_o       <= 1'b0;
      rdata_o     <= '0;
      busy_o      <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_we_o    <= 1'b0;
      mem_re_o    <= 1'b0;
`ifdef REG_ARB_ROUND_ROBIN_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      state       <= state_next;
      winner      <= winner_next;
      err_lat     <= err_lat_next;
      ack_o       <= ack_next;
      err_o       <= err_next;
      rdata_o     <= rdata_next;
      busy_o      <= busy_next;
      mem_addr_o  <= mem_addr_next;
      mem_wdata_o <= mem_wdata_next;
      mem_we_o    <= mem_we_next;
      mem_re_o    <= mem_re_next;
`ifdef REG_ARB_ROUND_ROBIN_EN
      last_grant  <= last_grant_next;
`endif
    end
  end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_access_arbiter
//
// Purpose:
//   Self-checking bench for reg_access_arbiter with the default parameters
//   (ADDR_WIDTH=7, DATA_WIDTH=8, NUM_REG=16). It starts with directed
//   scenarios that use hand-computed expectations, then switches to
//   randomised requester agents. A behavioural model runs the whole time,
//   and its expectations are compared with the DUT outputs on every cycle.
//   A small array stands in for the register map and drives mem_rdata_i.
//   The bench follows REG_ARB_ROUND_ROBIN_EN in the same way as the DUT.
// ---------------------------------------------------------------------------
module tb_reg_access_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [13:0] addr_i;
  logic [15:0] wdata_i;
  logic [1:0]  ack_o;
  logic        err_o;
  logic [7:0]  rdata_o;
  logic        busy_o;
  logic [6:0]  mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_we_o;
  logic        mem_re_o;
  logic [7:0]  mem_rdata_i;

  logic [7:0]  reg_file [16];

  int          checks;
  int          errors;
  int          cyc;

  logic        e_busy;
  logic        e_we;
  logic        e_re;
  logic [1:0]  e_ack;
  logic        e_err;
  logic [7:0]  e_rdata;
  logic [6:0]  e_addr;
  logic [7:0]  e_wdata;

  logic        pend;
  logic [1:0]  p_ack;
  logic        p_err;
  logic [7:0]  p_rdata;
  logic [6:0]  hold_addr;
  logic [7:0]  hold_wdata;
  logic        last_g;
  int          free_at;

  reg_access_arbiter #(
    .ADDR_WIDTH(7),
    .DATA_WIDTH(8),
    .NUM_REG(16)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(req_i),
    .we_i(we_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .ack_o(ack_o),
    .err_o(err_o),
    .rdata_o(rdata_o),
    .busy_o(busy_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_we_o(mem_we_o),
    .mem_re_o(mem_re_o),
    .mem_rdata_i(mem_rdata_i)
  );

  // Free-running clock, period 10.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Stand-in for the register map: combinational read of a fixed array.
  assign mem_rdata_i = reg_file[mem_addr_o[3:0]];

  // Single comparison point. Every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Drives the requester inputs.
  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] we,
                               input logic [13:0] addr, input logic [15:0] wdata);
    req_i   = req;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wdata;
  endtask

  // Advances one clock edge and returns 2 time units after it, which is
  // when inputs are changed.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Behavioural model, evaluated at each clock edge.
  // Timing rules it applies:
  //   - A grant fires at an edge where the arbiter is free and some request
  //     is high.
  //   - The strobe interval follows that edge and the ack interval follows
  //     the next one.
  //   - The arbiter is free again three edges after the grant.
  // On contention, round robin picks the requester not granted last time;
  // otherwise requester 0 wins. Out-of-range addresses produce an error
  // with no strobe, and the memory address and data outputs keep their
  // previous value.
  always @(posedge clk_i) begin
    logic       g;
    logic [6:0] a;
    logic [7:0] d;
    logic       w;
    cyc++;
    e_busy  = 1'b0;
    e_we    = 1'b0;
    e_re    = 1'b0;
    e_ack   = 2'b00;
    e_err   = 1'b0;
    e_rdata = 8'h00;
    if (rst_i) begin
      hold_addr  = 7'h00;
      hold_wdata = 8'h00;
      pend       = 1'b0;
      last_g     = 1'b1;
      free_at    = cyc + 1;
    end else if (pend) begin
      e_busy  = 1'b1;
      e_ack   = p_ack;
      e_err   = p_err;
      e_rdata = p_rdata;
      pend    = 1'b0;
    end else if (cyc >= free_at && req_i != 2'b00) begin
`ifdef REG_ARB_ROUND_ROBIN_EN
      g = (req_i == 2'b11) ? ~last_g : req_i[1];
`else
      g = (req_i == 2'b10);
`endif
      last_g = g;
      a = g ? addr_i[13:7] : addr_i[6:0];
      d = g ? wdata_i[15:8] : wdata_i[7:0];
      w = we_i[g];
      e_busy = 1'b1;
      if (a < 7'd16) begin
        hold_addr  = a;
        hold_wdata = d;
        e_we       = w;
        e_re       = ~w;
        p_err      = 1'b0;
        p_rdata    = w ? 8'h00 : reg_file[a[3:0]];
      end else begin
        p_err   = 1'b1;
        p_rdata = 8'h00;
      end
      p_ack   = g ? 2'b10 : 2'b01;
      pend    = 1'b1;
      free_at = cyc + 3;
    end
    e_addr  = hold_addr;
    e_wdata = hold_wdata;
  end

  // Compares every DUT output against the model in the middle of each cycle.
  // Read data is compared only while an ack is expected, because that is
  // the only time it is defined.
  initial begin
    @(posedge clk_i);
    forever begin
      @(negedge clk_i);
      checkOutput("busy_o", 32'(busy_o), 32'(e_busy));
      checkOutput("mem_we_o", 32'(mem_we_o), 32'(e_we));
      checkOutput("mem_re_o", 32'(mem_re_o), 32'(e_re));
      checkOutput("mem_addr_o", 32'(mem_addr_o), 32'(e_addr));
      checkOutput("mem_wdata_o", 32'(mem_wdata_o), 32'(e_wdata));
      checkOutput("ack_o", 32'(ack_o), 32'(e_ack));
      checkOutput("err_o", 32'(err_o), 32'(e_err));
      if (e_ack != 2'b00) checkOutput("rdata_o", 32'(rdata_o), 32'(e_rdata));
    end
  end

  // Directed scenarios with literal expectations, followed by random agents.
  initial begin
    logic [1:0]  r;
    logic [1:0]  w;
    logic [13:0] a;
    logic [15:0] d;
    logic [1:0]  exp_seq [4];
    int          cnt;
    logic        got;

    checks     = 0;
    errors     = 0;
    cyc        = 0;
    pend       = 1'b0;
    p_ack      = 2'b00;
    p_err      = 1'b0;
    p_rdata    = 8'h00;
    hold_addr  = 7'h00;
    hold_wdata = 8'h00;
    last_g     = 1'b1;
    free_at    = 0;
    for (int i = 0; i < 16; i++) reg_file[i] = 8'($urandom);
    reg_file[13] = 8'h3C;
    reg_file[5]  = 8'h5A;

    rst_i = 1'b1;
    applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
    tick();
    tick();
    checkOutput("reset_ack", 32'(ack_o), 32'h0);
    checkOutput("reset_busy", 32'(busy_o), 32'h0);
    rst_i = 1'b0;

    $display("[TB] write from requester 0");
    applyStimulus(2'b01, 2'b01, {7'h00, 7'h02}, {8'h00, 8'hA5});
    tick();
    @(negedge clk_i);
    checkOutput("wr_strobe", 32'(mem_we_o), 32'h1);
    checkOutput("wr_addr", 32'(mem_addr_o), 32'h02);
    checkOutput("wr_data", 32'(mem_wdata_o), 32'hA5);
    tick();
    @(negedge clk_i);
    checkOutput("wr_ack", 32'(ack_o), 32'h1);
    checkOutput("wr_err", 32'(err_o), 32'h0);
    applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
    tick();

    $display("[TB] read from requester 1");
    applyStimulus(2'b10, 2'b00, {7'h0D, 7'h00}, 16'h0);
    tick();
    @(negedge clk_i);
    checkOutput("rd_strobe", 32'(mem_re_o), 32'h1);
    tick();
    @(negedge clk_i);
    checkOutput("rd_ack", 32'(ack_o), 32'h2);
    checkOutput("rd_data", 32'(rdata_o), 32'h3C);
    applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
    tick();

    $display("[TB] out-of-range write");
    applyStimulus(2'b01, 2'b01, {7'h00, 7'h10}, {8'h00, 8'h77});
    tick();
    @(negedge clk_i);
    checkOutput("range_no_we", 32'(mem_we_o), 32'h0);
    checkOutput("range_no_re", 32'(mem_re_o), 32'h0);
    tick();
    @(negedge clk_i);
    checkOutput("range_ack", 32'(ack_o), 32'h1);
    checkOutput("range_err", 32'(err_o), 32'h1);
    checkOutput("range_rdata", 32'(rdata_o), 32'h0);
    applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
    tick();

    $display("[TB] contention held for four accesses");
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
`ifdef REG_ARB_ROUND_ROBIN_EN
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    applyStimulus(2'b11, 2'b00, {7'h04, 7'h03}, 16'h0);
    for (int k = 0; k < 4; k++) begin
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 6) begin
        tick();
        cnt++;
        @(negedge clk_i);
        if (ack_o != 2'b00) got = 1'b1;
      end
      checkOutput("contention_grant", 32'(ack_o), 32'(exp_seq[k]));
      checkOutput("ack_spacing", 32'(cnt), (k == 0) ? 32'd2 : 32'd3);
    end
    applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
    tick();
    tick();

    $display("[TB] reset during the strobe cycle");
    applyStimulus(2'b01, 2'b01, {7'h00, 7'h03}, {8'h00, 8'h99});
    tick();
    rst_i = 1'b1;
    applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
    tick();
    @(negedge clk_i);
    checkOutput("abort_ack", 32'(ack_o), 32'h0);
    checkOutput("abort_we", 32'(mem_we_o), 32'h0);
    checkOutput("abort_busy", 32'(busy_o), 32'h0);
    checkOutput("abort_addr", 32'(mem_addr_o), 32'h0);
    checkOutput("abort_wdata", 32'(mem_wdata_o), 32'h0);
    tick();
    rst_i = 1'b0;
    applyStimulus(2'b10, 2'b00, {7'h05, 7'h00}, 16'h0);
    tick();
    tick();
    @(negedge clk_i);
    checkOutput("post_reset_ack", 32'(ack_o), 32'h2);
    checkOutput("post_reset_rdata", 32'(rdata_o), 32'h5A);
    applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
    tick();

    $display("[TB] randomised requesters");
    for (int i = 0; i < 500; i++) begin
      r = req_i;
      w = we_i;
      a = addr_i;
      d = wdata_i;
      if ($urandom_range(0, 99) == 0) begin
        rst_i = 1'b1;
        r = 2'b00;
      end else begin
        rst_i = 1'b0;
        for (int n = 0; n < 2; n++) begin
          if (r[n] && ack_o[n]) begin
            if ($urandom_range(0, 3) != 0) begin
              r[n] = 1'b0;
            end else begin
              w[n] = 1'($urandom_range(0, 1));
              a[n*7 +: 7] = 7'($urandom_range(0, 19));
              d[n*8 +: 8] = 8'($urandom);
            end
          end else if (r[n]) begin
            if ($urandom_range(0, 3) == 0) begin
              w[n] = 1'($urandom_range(0, 1));
              a[n*7 +: 7] = 7'($urandom_range(0, 19));
              d[n*8 +: 8] = 8'($urandom);
            end
          end else if ($urandom_range(0, 2) == 0) begin
            r[n] = 1'b1;
            w[n] = 1'($urandom_range(0, 1));
            a[n*7 +: 7] = 7'($urandom_range(0, 19));
            d[n*8 +: 8] = 8'($urandom);
          end
        end
      end
      applyStimulus(r, w, a, d);
      tick();
    end
    rst_i = 1'b0;
    applyStimulus(2'b00, 2'b00, 14'h0, 16'h0);
    tick();
    tick();
    tick();
    @(negedge clk_i);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
